id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stall_in  in  1  global hold (memory/cache busy); freezes the stage.
REQ-005 flush_in  in  1  branch/jump redirect; the ID instruction is squashed.
REQ-006 ctrl_id  in  12  decoded controls: [11]RegDst [10]Jump [9]Branch [8]MemRead [7]MemtoReg [6:4]ALUOp [3]MemWrite [2]ALUSrc [1]RegWrite [0]Jal.
REQ-007 pc4_id  in  32  PC+4 of the ID instruction.
REQ-008 rs_data_id, rt_data_id  in  32 each  register-file read data.
REQ-009 imm_id  in  32  extended immediate.
REQ-010 rs_id, rt_id, rd_id  in  5 each  register indices.
REQ-011 funct_id  in  6  R-type function field.
REQ-012 ctrl_ex, pc4_ex, rs_data_ex, rt_data_ex, imm_ex, rs_ex, rt_ex, rd_ex, funct_ex  out  same widths  registered copies.
REQ-013 valid_ex  out  1  EX slot holds a real instruction (0 = bubble).
REQ-014 ctrl_flush  out  1  active-low decode kill to the decoder: 0 forces all decoded controls to 0.
REQ-015 pc_write, ifid_write  out  1 each  PC and IF/ID enables; 0 = hold.
REQ-016 bubble_cnt  out  CNT_W  saturating count of bubbles inserted.

Function
REQ-017 Load-use hazard (comb.): hz = valid_ex & ctrl_ex[8] & (rt_ex != 0) & ((rt_ex == rs_id) | (rt_ex == rt_id)).
REQ-018 ctrl_flush SHALL be 0 when hz | flush_in; else 1.
REQ-019 pc_write and ifid_write SHALL be 0 when hz | stall_in; else 1; flush_in alone does not deassert them.
REQ-020 Per-edge priority: rst > stall_in > flush_in > hz > normal load.
REQ-021 stall_in=1: all registered outputs and bubble_cnt hold; hz is still evaluated, driving ctrl_flush.
REQ-022 flush_in=1 or hz=1 (no stall): ctrl_ex <= 0, valid_ex <= 0; data fields (pc4, data, imm, indices, funct) <= 0.
REQ-023 Normal: all *_ex <= *_id, valid_ex <= 1; latency exactly 1 cycle.
REQ-024 Bubble counter increments by 1 on each edge where a bubble is inserted per REQ-022; saturates at all-ones, no wrap.
REQ-025 flush_in and hz in the same cycle count as one bubble.
REQ-026 A hazard lasts at most one cycle: the bubble clears valid_ex, so hz falls on the next cycle; no back-to-back hazard bubbles for one load.
REQ-027 rt_ex == 0 never raises hz (writes to $zero ignored).
REQ-028 Bubble ctrl_ex SHALL have RegWrite=0 and MemWrite=0, so a bubble never alters architectural state.

Reset
REQ-029 rst=1 at an edge: all *_ex outputs <= 0, valid_ex <= 0, bubble_cnt <= 0, regardless of stall_in or flush_in.
REQ-030 During and after reset, with valid_ex=0 and flush_in=0: ctrl_flush=1, pc_write=ifid_write=!stall_in.
REQ-031 Reset mid-hazard clears the hazard on the next cycle; no bubble is counted for that edge.

Verification
REQ-032 Pass-through: ctrl_id=12'h802 (R-type), rs_data_id=32'h1234, no stall/flush -> next cycle ctrl_ex=12'h802, rs_data_ex=32'h1234, valid_ex=1.
REQ-033 Load-use: EX holds lw (ctrl_ex[8]=1, rt_ex=8), ID has rs_id=8 -> same cycle ctrl_flush=0, pc_write=0, ifid_write=0; next cycle valid_ex=0, ctrl_ex=0, bubble_cnt=1; following cycle pc_write=1.
REQ-034 $zero: lw with rt_ex=0, rs_id=0 -> ctrl_flush=1, pc_write=1, no bubble.
REQ-035 Stall hold: stall_in=1 for 3 cycles with changing ID inputs -> *_ex and bubble_cnt unchanged, pc_write=0; after release, resumes with current ID values.
REQ-036 Flush vs stall: flush_in=1 and stall_in=1 -> hold; flush_in=1 alone -> valid_ex=0, pc_write=1, bubble_cnt+1.
REQ-037 Saturation and reset: CNT_W=2, 5 bubbles -> bubble_cnt=3; assert rst with stall_in=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with load-use hazard detection,
//                global stall hold, branch flush and a saturating bubble
//                counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_in,
    input  logic             flush_in,
    input  logic [11:0]      ctrl_id,
    input  logic [31:0]      pc4_id,
    input  logic [31:0]      rs_data_id,
    input  logic [31:0]      rt_data_id,
    input  logic [31:0]      imm_id,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic [4:0]       rd_id,
    input  logic [5:0]       funct_id,
    output logic [11:0]      ctrl_ex,
    output logic [31:0]      pc4_ex,
    output logic [31:0]      rs_data_ex,
    output logic [31:0]      rt_data_ex,
    output logic [31:0]      imm_ex,
    output logic [4:0]       rs_ex,
    output logic [4:0]       rt_ex,
    output logic [4:0]       rd_ex,
    output logic [5:0]       funct_ex,
    output logic             valid_ex,
    output logic             ctrl_flush,
    output logic             pc_write,
    output logic             ifid_write,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Bit position of MemRead within the decoded control word.
    localparam int C_MEMREAD_BIT = 8;

    logic w_hz;
    logic w_bubble;

    // A load in EX whose destination feeds the ID instruction must be
    // separated by one bubble; writes to $zero never create a dependency.
    assign w_hz = valid_ex
                & ctrl_ex[C_MEMREAD_BIT]
                & (rt_ex != 5'd0)
                & ((rt_ex == rs_id) | (rt_ex == rt_id));

    // Flush and hazard in the same cycle collapse into a single bubble.
    assign w_bubble   = flush_in | w_hz;

    // Decoder kill is active-low; the front end holds on hazard or stall,
    // but a redirect alone lets the fetch proceed to the new target.
    assign ctrl_flush = ~w_bubble;
    assign pc_write   = ~(w_hz | stall_in);
    assign ifid_write = ~(w_hz | stall_in);

    // Pipeline register: reset > stall hold > bubble insert > normal load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_ex    <= '0;
            pc4_ex     <= '0;
            rs_data_ex <= '0;
            rt_data_ex <= '0;
            imm_ex     <= '0;
            rs_ex      <= '0;
            rt_ex      <= '0;
            rd_ex      <= '0;
            funct_ex   <= '0;
            valid_ex   <= 1'b0;
            bubble_cnt <= '0;
        end else if (!stall_in) begin
            if (w_bubble) begin
                ctrl_ex    <= '0;
                pc4_ex     <= '0;
                rs_data_ex <= '0;
                rt_data_ex <= '0;
                imm_ex     <= '0;
                rs_ex      <= '0;
                rt_ex      <= '0;
                rd_ex      <= '0;
                funct_ex   <= '0;
                valid_ex   <= 1'b0;
                if (bubble_cnt != {CNT_W{1'b1}}) begin
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
                end
            end else begin
                ctrl_ex    <= ctrl_id;
                pc4_ex     <= pc4_id;
                rs_data_ex <= rs_data_id;
                rt_data_ex <= rt_data_id;
                imm_ex     <= imm_id;
                rs_ex      <= rs_id;
                rt_ex      <= rt_id;
                rd_ex      <= rd_id;
                funct_ex   <= funct_id;
                valid_ex   <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage (default counter width
//                and a 2-bit counter instance sharing the same stimulus).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall_in, flush_in;
    logic [11:0] ctrl_id;
    logic [31:0] pc4_id, rs_data_id, rt_data_id, imm_id;
    logic [4:0]  rs_id, rt_id, rd_id;
    logic [5:0]  funct_id;

    logic [11:0] ctrl_ex, ctrl_ex_s;
    logic [31:0] pc4_ex, rs_data_ex, rt_data_ex, imm_ex;
    logic [31:0] pc4_ex_s, rs_data_ex_s, rt_data_ex_s, imm_ex_s;
    logic [4:0]  rs_ex, rt_ex, rd_ex, rs_ex_s, rt_ex_s, rd_ex_s;
    logic [5:0]  funct_ex, funct_ex_s;
    logic        valid_ex, ctrl_flush, pc_write, ifid_write;
    logic        valid_ex_s, ctrl_flush_s, pc_write_s, ifid_write_s;
    logic [15:0] bubble_cnt;
    logic [1:0]  bubble_cnt_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
        .ctrl_id(ctrl_id), .pc4_id(pc4_id), .rs_data_id(rs_data_id),
        .rt_data_id(rt_data_id), .imm_id(imm_id), .rs_id(rs_id),
        .rt_id(rt_id), .rd_id(rd_id), .funct_id(funct_id),
        .ctrl_ex(ctrl_ex), .pc4_ex(pc4_ex), .rs_data_ex(rs_data_ex),
        .rt_data_ex(rt_data_ex), .imm_ex(imm_ex), .rs_ex(rs_ex),
        .rt_ex(rt_ex), .rd_ex(rd_ex), .funct_ex(funct_ex),
        .valid_ex(valid_ex), .ctrl_flush(ctrl_flush), .pc_write(pc_write),
        .ifid_write(ifid_write), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
        .ctrl_id(ctrl_id), .pc4_id(pc4_id), .rs_data_id(rs_data_id),
        .rt_data_id(rt_data_id), .imm_id(imm_id), .rs_id(rs_id),
        .rt_id(rt_id), .rd_id(rd_id), .funct_id(funct_id),
        .ctrl_ex(ctrl_ex_s), .pc4_ex(pc4_ex_s), .rs_data_ex(rs_data_ex_s),
        .rt_data_ex(rt_data_ex_s), .imm_ex(imm_ex_s), .rs_ex(rs_ex_s),
        .rt_ex(rt_ex_s), .rd_ex(rd_ex_s), .funct_ex(funct_ex_s),
        .valid_ex(valid_ex_s), .ctrl_flush(ctrl_flush_s), .pc_write(pc_write_s),
        .ifid_write(ifid_write_s), .bubble_cnt(bubble_cnt_s)
    );

    // Expected EX-side state of the stage.
    typedef struct {
        logic [11:0] ctrl;
        logic [31:0] pc4, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct;
        logic        valid;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } st_t;

    st_t mdl;
    st_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic hz_of(input st_t s);
        return s.valid & s.ctrl[8] & (s.rt != 5'd0) & ((s.rt == rs_id) | (s.rt == rt_id));
    endfunction

    function automatic st_t zero_st();
        st_t z;
        z.ctrl = '0; z.pc4 = '0; z.rsd = '0; z.rtd = '0; z.imm = '0;
        z.rs = '0; z.rt = '0; z.rd = '0; z.funct = '0; z.valid = 1'b0;
        z.cnt = '0; z.cnt2 = '0;
        return z;
    endfunction

    // Next EX state from the current expected state and the driven inputs.
    function automatic st_t next_of(input st_t s);
        st_t n;
        n = s;
        if (rst) begin
            n = zero_st();
        end else if (stall_in) begin
            n = s;
        end else if (flush_in | hz_of(s)) begin
            n = zero_st();
            n.cnt  = (s.cnt  == 16'hFFFF) ? s.cnt  : s.cnt + 16'd1;
            n.cnt2 = (s.cnt2 == 2'b11)    ? s.cnt2 : s.cnt2 + 2'd1;
        end else begin
            n.ctrl = ctrl_id; n.pc4 = pc4_id; n.rsd = rs_data_id;
            n.rtd = rt_data_id; n.imm = imm_id; n.rs = rs_id; n.rt = rt_id;
            n.rd = rd_id; n.funct = funct_id; n.valid = 1'b1;
        end
        return n;
    endfunction

    // One clock: check combinational outputs, push expectation, compare after edge.
    task automatic step(input string tag);
        st_t e;
        logic hz;
        @(negedge clk);
        hz = hz_of(mdl);
        chk({tag, "/ctrl_flush"}, {31'd0, ctrl_flush}, {31'd0, !(hz | flush_in)});
        chk({tag, "/pc_write"},   {31'd0, pc_write},   {31'd0, !(hz | stall_in)});
        chk({tag, "/ifid_write"}, {31'd0, ifid_write}, {31'd0, !(hz | stall_in)});
        chk({tag, "/pc_write_s"}, {31'd0, pc_write_s}, {31'd0, !(hz | stall_in)});
        sb.push_back(next_of(mdl));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, "/ctrl_ex"},    {20'd0, ctrl_ex},   {20'd0, e.ctrl});
        chk({tag, "/pc4_ex"},     pc4_ex,             e.pc4);
        chk({tag, "/rs_data_ex"}, rs_data_ex,         e.rsd);
        chk({tag, "/rt_data_ex"}, rt_data_ex,         e.rtd);
        chk({tag, "/imm_ex"},     imm_ex,             e.imm);
        chk({tag, "/idx_ex"},     {17'd0, rs_ex, rt_ex, rd_ex}, {17'd0, e.rs, e.rt, e.rd});
        chk({tag, "/funct_ex"},   {26'd0, funct_ex},  {26'd0, e.funct});
        chk({tag, "/valid_ex"},   {31'd0, valid_ex},  {31'd0, e.valid});
        chk({tag, "/bubble_cnt"}, {16'd0, bubble_cnt}, {16'd0, e.cnt});
        chk({tag, "/bubble_cnt_s"}, {30'd0, bubble_cnt_s}, {30'd0, e.cnt2});
        mdl = e;
    endtask

    task automatic set_id(input logic [11:0] c, input logic [31:0] rsd,
                          input logic [4:0] rs, input logic [4:0] rt);
        ctrl_id = c; rs_data_id = rsd; rs_id = rs; rt_id = rt;
        pc4_id = $urandom; rt_data_id = $urandom; imm_id = $urandom;
        rd_id = 5'($urandom); funct_id = 6'($urandom);
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b1; flush_in = 1'b1;
        set_id(12'hFFF, 32'hDEAD, 5'd3, 5'd4);
        @(posedge clk);
        #1;
        mdl = zero_st();

        // Reset wins over stall and flush.
        step("reset0");
        flush_in = 1'b0;
        step("reset1");
        chk("reset_pc_write_stalled", {31'd0, pc_write}, 32'd0);
        stall_in = 1'b0;
        rst = 1'b0;

        // Pass-through of an R-type instruction.
        set_id(12'h802, 32'h1234, 5'd1, 5'd2);
        step("pass");
        chk("pass_ctrl", {20'd0, ctrl_ex}, 32'h802);
        chk("pass_rsd", rs_data_ex, 32'h1234);
        chk("pass_valid", {31'd0, valid_ex}, 32'd1);

        // Load-use: lw writes r8, next instruction reads r8.
        set_id(12'h186, 32'h0, 5'd9, 5'd8);
        step("lw");
        set_id(12'h802, 32'h55, 5'd8, 5'd1);
        #1;
        chk("lu_ctrl_flush", {31'd0, ctrl_flush}, 32'd0);
        chk("lu_pc_write", {31'd0, pc_write}, 32'd0);
        step("lu_bubble");
        chk("lu_valid", {31'd0, valid_ex}, 32'd0);
        chk("lu_ctrl", {20'd0, ctrl_ex}, 32'd0);
        chk("lu_cnt", {16'd0, bubble_cnt}, 32'd1);
        chk("lu_pc_write_after", {31'd0, pc_write}, 32'd1);
        step("lu_resume");

        // Load to $zero never stalls.
        set_id(12'h186, 32'h0, 5'd0, 5'd0);
        step("lw_zero");
        set_id(12'h802, 32'h77, 5'd0, 5'd0);
        #1;
        chk("zero_ctrl_flush", {31'd0, ctrl_flush}, 32'd1);
        chk("zero_pc_write", {31'd0, pc_write}, 32'd1);
        step("zero_next");

        // Stall hold with changing ID inputs, then resume.
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(12'($urandom), $urandom, 5'($urandom), 5'($urandom));
            step("stall");
        end
        stall_in = 1'b0;
        set_id(12'h802, 32'hABCD, 5'd2, 5'd3);
        step("stall_release");
        chk("release_rsd", rs_data_ex, 32'hABCD);

        // Flush with stall holds; flush alone bubbles.
        flush_in = 1'b1; stall_in = 1'b1;
        step("flush_stall");
        stall_in = 1'b0;
        step("flush_only");
        chk("flush_valid", {31'd0, valid_ex}, 32'd0);
        flush_in = 1'b0;

        // Reset in the middle of a hazard cycle.
        set_id(12'h186, 32'h0, 5'd1, 5'd5);
        step("lw5");
        set_id(12'h802, 32'h1, 5'd5, 5'd6);
        rst = 1'b1;
        step("rst_mid_hz");
        rst = 1'b0;
        chk("rst_mid_cnt", {16'd0, bubble_cnt}, 32'd0);
        step("after_rst_hz");

        // Hazard together with flush counts as one bubble.
        set_id(12'h186, 32'h0, 5'd1, 5'd7);
        step("lw7");
        set_id(12'h802, 32'h1, 5'd7, 5'd7);
        flush_in = 1'b1;
        step("hz_and_flush");
        flush_in = 1'b0;

        // Mixed random traffic with frequent register collisions.
        for (int i = 0; i < 30; i++) begin
            set_id(12'($urandom) | (($urandom_range(0, 1) == 1) ? 12'h100 : 12'h000),
                   $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            flush_in = ($urandom_range(0, 5) == 0);
            stall_in = ($urandom_range(0, 5) == 0);
            step("rand");
        end
        flush_in = 1'b0; stall_in = 1'b0;

        // Saturation of the 2-bit counter, then reset under stall.
        rst = 1'b1;
        step("sat_rst");
        rst = 1'b0;
        flush_in = 1'b1;
        for (int i = 0; i < 5; i++) step("sat_flush");
        flush_in = 1'b0;
        chk("sat_cnt2", {30'd0, bubble_cnt_s}, 32'd3);
        chk("sat_cnt16", {16'd0, bubble_cnt}, 32'd5);
        set_id(12'h802, 32'h99, 5'd1, 5'd2);
        step("sat_load");
        rst = 1'b1; stall_in = 1'b1;
        step("final_rst");
        chk("final_valid", {31'd0, valid_ex}, 32'd0);
        chk("final_cnt2", {30'd0, bubble_cnt_s}, 32'd0);
        chk("final_ctrl", {20'd0, ctrl_ex}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
